// File: rtl/alu_muldiv_sequencer.sv
// Iterative multiply / unsigned divide sequencer that borrows the execute-stage
// ALU for every add, subtract and compare it needs. Multiply is 32 shift-add
// steps; divide is 32 compare/subtract bit pairs (64 cycles, restoring).
module alu_muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_s
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_ADD  = 3'b010;
    localparam logic [2:0] F_SUB  = 3'b110;
    localparam logic [2:0] F_SLTU = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DCMP = 3'd2,
        S_DSUB = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e state_q, state_d;

    // acc_q is the product accumulator for multiply and the remainder for divide.
    // b_q is the (shifting) multiplicand or the fixed divisor.
    // q_q is the (shifting) multiplier or the dividend/quotient register.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q,   b_d;
    logic [WIDTH-1:0] q_q,   q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ge_q,  ge_d;

    logic [WIDTH-1:0] result_lo_q, result_lo_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             div0_q,      div0_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [WIDTH-1:0] alu_a_q,     alu_a_d;
    logic [WIDTH-1:0] alu_b_q,     alu_b_d;
    logic [2:0]       alu_f_q,     alu_f_d;

    logic             last_step;
    logic [WIDTH-1:0] sh;

    assign last_step = (cnt_q == CNT_LAST);
    // Partial remainder shifted left with the next dividend bit brought in.
    assign sh        = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!op) begin
                        state_d = S_MUL;
                    end else if (op_b == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DCMP;
                    end
                end
            end
            S_MUL:   state_d = last_step ? S_DONE : S_MUL;
            S_DCMP:  state_d = S_DSUB;
            S_DSUB:  state_d = last_step ? S_DONE : S_DCMP;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and result next values; every arithmetic step is taken from alu_s.
    always_comb begin
        acc_d       = acc_q;
        b_d         = b_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        ge_d        = ge_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        div0_d      = div0_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d  = '0;
                    cnt_d  = '0;
                    ge_d   = 1'b0;
                    div0_d = 1'b0;
                    if (op) begin
                        q_d = op_a;
                        b_d = op_b;
                        if (op_b == '0) begin
                            result_lo_d = '1;
                            result_hi_d = op_a;
                            div0_d      = 1'b1;
                        end
                    end else begin
                        b_d = op_a;
                        q_d = op_b;
                    end
                end
            end
            S_MUL: begin
                acc_d = alu_s;
                b_d   = b_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    result_lo_d = alu_s;
                    result_hi_d = '0;
                end
            end
            S_DCMP: begin
                // A set carry means the shifted remainder exceeds 32 bits, so it
                // is certainly >= divisor; otherwise trust the unsigned compare.
                acc_d = sh;
                q_d   = q_q << 1;
                ge_d  = acc_q[WIDTH-1] | ~alu_s[0];
            end
            S_DSUB: begin
                if (ge_q) begin
                    acc_d = alu_s;
                    q_d   = {q_q[WIDTH-1:1], 1'b1};
                end else begin
                    q_d   = {q_q[WIDTH-1:1], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    result_lo_d = q_d;
                    result_hi_d = acc_d;
                end
            end
            default: ;
        endcase
    end

    // Output next values, looked ahead from the next state so the registered
    // ALU operands line up with the cycle that consumes alu_s.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        alu_a_d = '0;
        alu_b_d = '0;
        alu_f_d = F_NONE;
        case (state_d)
            S_MUL: begin
                busy_d  = 1'b1;
                alu_a_d = acc_d;
                alu_b_d = q_d[0] ? b_d : '0;
                alu_f_d = F_ADD;
            end
            S_DCMP: begin
                busy_d  = 1'b1;
                alu_a_d = {acc_d[WIDTH-2:0], q_d[WIDTH-1]};
                alu_b_d = b_d;
                alu_f_d = F_SLTU;
            end
            S_DSUB: begin
                busy_d  = 1'b1;
                alu_a_d = acc_d;
                alu_b_d = b_d;
                alu_f_d = F_SUB;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            b_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            ge_q        <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            div0_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= F_NONE;
        end else begin
            acc_q       <= acc_d;
            b_q         <= b_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            ge_q        <= ge_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            div0_q      <= div0_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_f_q     <= alu_f_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div0      = div0_q;
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_f     = alu_f_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer with a behavioural ALU attached.
module tb_alu_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_s;

    int n_checks;
    int n_errors;

    alu_muldiv_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .div0      (div0),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_s     (alu_s)
    );

    // Datapath ALU the sequencer borrows.
    always_comb begin
        case (alu_f)
            3'b000:  alu_s = alu_a & alu_b;
            3'b001:  alu_s = alu_a | alu_b;
            3'b010:  alu_s = alu_a + alu_b;
            3'b110:  alu_s = alu_a - alu_b;
            3'b111:  alu_s = {31'd0, (alu_a < alu_b)};
            default: alu_s = 32'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    // Issue one operation and watch it; sampling is 1 time unit after each edge.
    // lat = edges after E0 until done is seen (-1 on timeout).
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output int f_bad,
                          output int div0_e0);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'hDEAD_BEEF;
        lat      = -1;
        busy_cnt = 0;
        f_bad    = 0;
        div0_e0  = int'(div0);
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) begin
                busy_cnt++;
                if (o && (alu_f != ((k % 2 == 0) ? 3'b111 : 3'b110))) f_bad++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        string       name;
        logic        o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        d0;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat, bcnt, fbad, d0e0, dcount, bseen;
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_done",  32'(done), 32'd0);
        check_eq("rst_div0",  32'(div0), 32'd0);
        check_eq("rst_lo",    result_lo, 32'd0);
        check_eq("rst_hi",    result_hi, 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_alu_b", alu_b, 32'd0);
        check_eq("rst_alu_f", 32'(alu_f), 32'd0);
        rst = 1'b0;

        vecs.push_back('{"mul_7x6",      1'b0, 32'd7,         32'd6,         32'd42,        32'd0,         1'b0, 32});
        vecs.push_back('{"mul_ffxff",    1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  32'd0,         1'b0, 32});
        vecs.push_back('{"mul_0x",       1'b0, 32'd0,         32'h12345678,  32'd0,         32'd0,         1'b0, 32});
        vecs.push_back('{"div_100_7",    1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 64});
        vecs.push_back('{"div_carry",    1'b1, 32'hFFFFFFFF,  32'h80000001,  32'd1,         32'h7FFFFFFE,  1'b0, 64});
        vecs.push_back('{"div_ff_1",     1'b1, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0, 64});
        vecs.push_back('{"div_5_0",      1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 0});
        vecs.push_back('{"mul_after_d0", 1'b0, 32'd2,         32'd3,         32'd6,         32'd0,         1'b0, 32});

        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, lat, bcnt, fbad, d0e0);
            check_eq({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].lat));
            check_eq({vecs[i].name, "_busy"}, 32'(bcnt), 32'(vecs[i].lat));
            check_eq({vecs[i].name, "_lo"},   result_lo, vecs[i].lo);
            check_eq({vecs[i].name, "_hi"},   result_hi, vecs[i].hi);
            check_eq({vecs[i].name, "_div0"}, 32'(div0), 32'(vecs[i].d0));
            if (vecs[i].o) check_eq({vecs[i].name, "_alu_f_alt"}, 32'(fbad), 32'd0);
            if (vecs[i].name == "mul_after_d0") check_eq("div0_clear_at_start", 32'(d0e0), 32'd0);
            @(posedge clk);
            #1;
            check_eq({vecs[i].name, "_done_1cyc"}, 32'(done), 32'd0);
            check_eq({vecs[i].name, "_lo_held"},   result_lo, vecs[i].lo);
        end

        // Reset during step 10 of a multiply aborts it silently.
        @(negedge clk);
        start = 1'b1; op = 1'b0; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_busy",  32'(busy), 32'd0);
        check_eq("abort_done",  32'(done), 32'd0);
        check_eq("abort_lo",    result_lo, 32'd0);
        check_eq("abort_hi",    result_hi, 32'd0);
        check_eq("abort_alu_a", alu_a, 32'd0);
        check_eq("abort_alu_b", alu_b, 32'd0);
        check_eq("abort_alu_f", 32'(alu_f), 32'd0);
        dcount = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check_eq("abort_no_done", 32'(dcount), 32'd0);

        // Start pulses while busy and while done must be ignored.
        @(negedge clk);
        start = 1'b1; op = 1'b0; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op = 1'b1; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_eq("ign_done_seen", 32'(lat >= 0), 32'd1);
        check_eq("ign_lo", result_lo, 32'd15);
        check_eq("ign_hi", result_hi, 32'd0);
        start = 1'b1; op = 1'b0; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcount = 0;
        bseen  = 0;
        for (int k = 0; k < 80; k++) begin
            if (done) dcount++;
            if (busy) bseen++;
            @(posedge clk);
            #1;
        end
        check_eq("ign_extra_done", 32'(dcount), 32'd0);
        check_eq("ign_extra_busy", 32'(bseen), 32'd0);
        check_eq("ign_lo_held", result_lo, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
- Iterative multiply/divide initiator that reuses the datapath ALU (f-coded: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 unsigned SLT; combinational s, zero) instead of owning an adder.
- Drives the ALU operand and function inputs and consumes s each cycle.
- Implements a 32-cycle shift-add multiply (low 32 bits) and a 64-cycle restoring unsigned divide.
- Sits beside the execute stage; the core stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; the ALU interface is fixed at 32 bits, so only 32 is supported.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when idle (busy=0 and done=0)
- op  input  1  0 = multiply, 1 = unsigned divide
- op_a  input  32  multiplicand / dividend, captured on an accepted start
- op_b  input  32  multiplier / divisor, captured on an accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, results valid
- div0  output  1  high with done when the divisor was 0; held until the next accepted start
- result_lo  output  32  product low word or quotient; held until the next accepted start
- result_hi  output  32  remainder; 0 for multiply
- alu_a  output  32  to ALU A
- alu_b  output  32  to ALU B
- alu_f  output  3  to ALU f
- alu_s  input  32  from ALU s

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE; busy, done, div0 = 0; result_lo, result_hi = 0; alu_a, alu_b = 0; alu_f = 000.
- A reset mid-operation aborts the operation with no done pulse.
- States: IDLE, MUL, DCMP, DSUB, DONE.
- IDLE:
  - ALU outputs are 0/0/000.
  - On start (edge E0): capture operands, clear acc/rem, set cnt=0, clear div0.
  - Transition: op=0 -> MUL; op=1 and op_b!=0 -> DCMP; op=1 and op_b=0 -> DONE with result_lo=FFFFFFFF, result_hi=op_a, div0=1.
- MUL (32 cycles):
  - Drive alu_a=acc, alu_b=(mplier[0] ? mcand : 0), alu_f=010.
  - At the edge: acc<=alu_s, mcand<<=1, mplier>>=1, cnt++.
  - After the 32nd step go to DONE with result_lo=acc, result_hi=0.
  - Overflow beyond 32 bits is discarded.
- Divide uses registers rem and quo (quo initialised to the dividend).
- DCMP:
  - Form sh={rem[30:0],quo[31]} and carry c=rem[31].
  - Drive alu_a=sh, alu_b=divisor, alu_f=111.
  - At the edge: latch sh into rem, shift quo left by 1, and set ge = c | (alu_s[0]==0). Go to DSUB.
- DSUB:
  - Drive alu_a=rem, alu_b=divisor, alu_f=110.
  - If ge: rem<=alu_s and quo[0]<=1. Otherwise rem holds and quo[0]<=0.
  - cnt++. After the 32nd bit go to DONE with result_lo=quo, result_hi=rem; else go to DCMP.
  - The carry path relies on modulo-2^32 subtraction being exact.
- Fixed latency is independent of operand values. The ALU function is driven on both the compare and subtract cycles even when the result is unused.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start during DONE is ignored.
- busy=1 in MUL, DCMP and DSUB; 0 otherwise.
- Latency, counted from the accepting edge E0:
  - done is high in the cycle after E32 (multiply) or after E64 (divide).
  - For divide by zero, done is high in the cycle after E0.
- start while busy or done is ignored. Operands are not re-sampled during an operation.

Test Plan:
- Multiply 7 x 6, ALU instance connected: done pulses in the cycle after E32, result_lo=42, result_hi=0, div0=0, busy high for exactly 32 cycles.
- Multiply FFFFFFFF x FFFFFFFF: result_lo=00000001. Also check that 0 x 12345678 gives 0.
- Divide 100 / 7: done in the cycle after E64, result_lo=14, result_hi=2. Also check that alu_f alternates 111/110 throughout.
- Divide FFFFFFFF / 80000001 (exercises the carry path): result_lo=1, result_hi=7FFFFFFE. Also check that FFFFFFFF / 1 gives quotient FFFFFFFF and remainder 0.
- Divide 5 / 0: done in the cycle after E0, div0=1, result_lo=FFFFFFFF, result_hi=5. div0 clears on the next accepted start.
- Assert rst at step 10 of a multiply: the next cycle shows busy=0, done=0, results 0 and ALU outputs 0/0/000, and no done pulse follows. Separately, start pulses during busy and during DONE are ignored: only one done pulse, with results from the first operands.
